dual_port_ssram_be: RTL and testbench

- Next-generation single-clock true dual-port synchronous RAM for the DMA module; successor to the basic two-port SSRAM.
- Adds per-byte write enables, explicit access enables with read-valid outputs, and a selectable 1- or 2-cycle read pipeline.
- Defines deterministic same-address collision rules and provides a hardware clear engine that zeroes memory after reset.
- Sits between the DMA engine (port A) and the bus-side buffer logic (port B).

---
 rtl/dual_port_ssram_be.sv | 163 ++++++++++++++++
 tb/tb_dual_port_ssram_be.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ssram_be.sv
// dual_port_ssram_be
// Single-clock true dual-port RAM with per-byte write enables, read-valid
// strobes, a 1- or 2-stage read pipeline and a post-reset clear engine.
// Optional collision flag: define DPRAM_COLLISION_FLAG_EN.
//
// state  | meaning
// CLEAR  | clear engine zeroes one entry per cycle, accesses ignored, busy=1
// READY  | normal access, terminal until the next reset
module dual_port_ssram_be #(
  parameter int bitwidth       = 32,
  parameter int nrOfEntries    = 512,
  parameter int readAfterWrite = 0,
  parameter int readLatency    = 1,
  parameter int clearOnReset   = 1,
  localparam int AW = $clog2(nrOfEntries),
  localparam int NB = bitwidth / 8
) (
  input  logic                clock,
  input  logic                reset,
  output logic                busy,
  input  logic                enableA,
  input  logic                writeEnableA,
  input  logic [NB-1:0]       byteEnableA,
  input  logic [AW-1:0]       addressA,
  input  logic [bitwidth-1:0] dataInA,
  output logic [bitwidth-1:0] dataOutA,
  output logic                validOutA,
  input  logic                enableB,
  input  logic                writeEnableB,
  input  logic [NB-1:0]       byteEnableB,
  input  logic [AW-1:0]       addressB,
  input  logic [bitwidth-1:0] dataInB,
  output logic [bitwidth-1:0] dataOutB,
  output logic                validOutB
`ifdef DPRAM_COLLISION_FLAG_EN
  , input  logic              clearCollision
  , output logic              collisionFlag
`endif
);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(nrOfEntries - 1);

  logic [bitwidth-1:0] mem_q [nrOfEntries];

  state_t              state_q;
  logic                busy_q;
  logic [AW-1:0]       cnt_q;

  logic                in_range_a, in_range_b;
  logic                acc_a, acc_b;
  logic                wr_a, wr_b;
  logic [bitwidth-1:0] rd_a_d, rd_b_d;

  logic [bitwidth-1:0] d1a_q, d2a_q, d1b_q, d2b_q;
  logic                v1a_q, v2a_q, v1b_q, v2b_q;

  assign in_range_a = (32'(addressA) < 32'(nrOfEntries));
  assign in_range_b = (32'(addressB) < 32'(nrOfEntries));

  // Out-of-range accesses still count as accesses (valid pulses) but never write.
  assign acc_a = (state_q == S_READY) && enableA;
  assign acc_b = (state_q == S_READY) && enableB;
  assign wr_a  = acc_a && writeEnableA && in_range_a;
  assign wr_b  = acc_b && writeEnableB && in_range_b;

  // Clear engine: walks entries 0..nrOfEntries-1, then parks in READY.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= (clearOnReset != 0) ? S_CLEAR : S_READY;
      busy_q  <= (clearOnReset != 0);
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          if (cnt_q == LAST_ADDR) begin
            state_q <= S_READY;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = busy_q;

  // Memory array: clear writes, else per-lane writes with port A issued last so it wins overlaps.
  always_ff @(posedge clock) begin
    if (state_q == S_CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (wr_b && byteEnableB[i]) mem_q[addressB][8*i +: 8] <= dataInB[8*i +: 8];
      end
      for (int i = 0; i < NB; i++) begin
        if (wr_a && byteEnableA[i]) mem_q[addressA][8*i +: 8] <= dataInA[8*i +: 8];
      end
    end
  end

  // Read data: stored word, optionally overlaid with this cycle's writes (B first, A on top).
  always_comb begin
    rd_a_d = '0;
    rd_b_d = '0;
    if (in_range_a) rd_a_d = mem_q[addressA];
    if (in_range_b) rd_b_d = mem_q[addressB];
    if (readAfterWrite != 0) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_b && (addressB == addressA) && byteEnableB[i]) rd_a_d[8*i +: 8] = dataInB[8*i +: 8];
        if (wr_a && byteEnableA[i])                           rd_a_d[8*i +: 8] = dataInA[8*i +: 8];
        if (wr_b && byteEnableB[i])                           rd_b_d[8*i +: 8] = dataInB[8*i +: 8];
        if (wr_a && (addressA == addressB) && byteEnableA[i]) rd_b_d[8*i +: 8] = dataInA[8*i +: 8];
      end
    end
  end

  // Read pipeline: data registers only load with a valid, so outputs hold the last result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      d1a_q <= '0;  d2a_q <= '0;  v1a_q <= 1'b0;  v2a_q <= 1'b0;
      d1b_q <= '0;  d2b_q <= '0;  v1b_q <= 1'b0;  v2b_q <= 1'b0;
    end else begin
      v1a_q <= acc_a;
      if (acc_a) d1a_q <= rd_a_d;
      v2a_q <= v1a_q;
      if (v1a_q) d2a_q <= d1a_q;
      v1b_q <= acc_b;
      if (acc_b) d1b_q <= rd_b_d;
      v2b_q <= v1b_q;
      if (v1b_q) d2b_q <= d1b_q;
    end
  end

  assign dataOutA  = (readLatency == 2) ? d2a_q : d1a_q;
  assign validOutA = (readLatency == 2) ? v2a_q : v1a_q;
  assign dataOutB  = (readLatency == 2) ? d2b_q : d1b_q;
  assign validOutB = (readLatency == 2) ? v2b_q : v1b_q;

`ifdef DPRAM_COLLISION_FLAG_EN
  logic col_q;
  logic col_event;

  assign col_event = acc_a && acc_b && (addressA == addressB) && (writeEnableA || writeEnableB);

  // Sticky collision flag; a new collision beats a simultaneous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_q <= 1'b0;
    end else if (col_event) begin
      col_q <= 1'b1;
    end else if (clearCollision) begin
      col_q <= 1'b0;
    end
  end

  assign collisionFlag = col_q;
`endif

endmodule

// File: tb/tb_dual_port_ssram_be.sv
// Directed bench for dual_port_ssram_be. Two instances share all inputs:
//   u_main: 16 entries, pre-write reads, 1-cycle latency
//   u_alt : 12 entries, post-write reads, 2-cycle latency (exercises out-of-range)
module tb_dual_port_ssram_be;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enableA = 1'b0, writeEnableA = 1'b0, enableB = 1'b0, writeEnableB = 1'b0;
  logic [3:0]  byteEnableA = '0, byteEnableB = '0, addressA = '0, addressB = '0;
  logic [31:0] dataInA = '0, dataInB = '0;

  logic        busy, validOutA, validOutB;
  logic [31:0] dataOutA, dataOutB;
  logic        busy2, validOutA2, validOutB2;
  logic [31:0] dataOutA2, dataOutB2;
`ifdef DPRAM_COLLISION_FLAG_EN
  logic        clearCollision = 1'b0;
  logic        collisionFlag, collisionFlag2;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  dual_port_ssram_be #(
    .bitwidth(32), .nrOfEntries(16), .readAfterWrite(0), .readLatency(1), .clearOnReset(1)
  ) u_main (
    .clock(clock), .reset(reset), .busy(busy),
    .enableA(enableA), .writeEnableA(writeEnableA), .byteEnableA(byteEnableA),
    .addressA(addressA), .dataInA(dataInA), .dataOutA(dataOutA), .validOutA(validOutA),
    .enableB(enableB), .writeEnableB(writeEnableB), .byteEnableB(byteEnableB),
    .addressB(addressB), .dataInB(dataInB), .dataOutB(dataOutB), .validOutB(validOutB)
`ifdef DPRAM_COLLISION_FLAG_EN
    , .clearCollision(clearCollision), .collisionFlag(collisionFlag)
`endif
  );

  dual_port_ssram_be #(
    .bitwidth(32), .nrOfEntries(12), .readAfterWrite(1), .readLatency(2), .clearOnReset(1)
  ) u_alt (
    .clock(clock), .reset(reset), .busy(busy2),
    .enableA(enableA), .writeEnableA(writeEnableA), .byteEnableA(byteEnableA),
    .addressA(addressA), .dataInA(dataInA), .dataOutA(dataOutA2), .validOutA(validOutA2),
    .enableB(enableB), .writeEnableB(writeEnableB), .byteEnableB(byteEnableB),
    .addressB(addressB), .dataInB(dataInB), .dataOutB(dataOutB2), .validOutB(validOutB2)
`ifdef DPRAM_COLLISION_FLAG_EN
    , .clearCollision(clearCollision), .collisionFlag(collisionFlag2)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_a(input logic en, input logic we, input logic [3:0] be,
                       input logic [3:0] ad, input logic [31:0] d);
    enableA = en; writeEnableA = we; byteEnableA = be; addressA = ad; dataInA = d;
  endtask

  task automatic set_b(input logic en, input logic we, input logic [3:0] be,
                       input logic [3:0] ad, input logic [31:0] d);
    enableB = en; writeEnableB = we; byteEnableB = be; addressB = ad; dataInB = d;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic        en_a, we_a;
    logic [3:0]  be_a, ad_a;
    logic [31:0] d_a;
    logic        en_b, we_b;
    logic [3:0]  be_b, ad_b;
    logic [31:0] d_b;
    logic        xv_a;
    logic [31:0] xd_a;
    logic        xv_b;
    logic [31:0] xd_b;
    logic        xcol;
  } vec_t;

  vec_t vec[11];

  initial begin
    int n, n2;

    // en we be addr data (A) | en we be addr data (B) | expected vA dA vB dB col (main instance)
    vec[0]  = '{1'b1,1'b0,4'h0,4'd5,32'h0,        1'b0,1'b0,4'h0,4'd0,32'h0,
                1'b1,32'h0,        1'b0,32'h0,        1'b0};
    vec[1]  = '{1'b1,1'b1,4'hF,4'd3,32'hAABBCCDD, 1'b0,1'b0,4'h0,4'd0,32'h0,
                1'b1,32'h0,        1'b0,32'h0,        1'b0};
    vec[2]  = '{1'b0,1'b0,4'h0,4'd0,32'h0,        1'b1,1'b1,4'h5,4'd3,32'h11223344,
                1'b0,32'h0,        1'b1,32'hAABBCCDD, 1'b0};
    vec[3]  = '{1'b1,1'b0,4'h0,4'd3,32'h0,        1'b0,1'b0,4'h0,4'd0,32'h0,
                1'b1,32'hAA22CC44, 1'b0,32'hAABBCCDD, 1'b0};
    vec[4]  = '{1'b1,1'b1,4'h1,4'd7,32'h000000FF, 1'b1,1'b1,4'hF,4'd7,32'h12345678,
                1'b1,32'h0,        1'b1,32'h0,        1'b1};
    vec[5]  = '{1'b1,1'b0,4'h0,4'd7,32'h0,        1'b1,1'b0,4'h0,4'd3,32'h0,
                1'b1,32'h123456FF, 1'b1,32'hAA22CC44, 1'b1};
    vec[6]  = '{1'b1,1'b1,4'hF,4'd2,32'h1,        1'b0,1'b0,4'h0,4'd0,32'h0,
                1'b1,32'h0,        1'b0,32'hAA22CC44, 1'b1};
    vec[7]  = '{1'b1,1'b1,4'hF,4'd2,32'h9,        1'b1,1'b0,4'h0,4'd2,32'h0,
                1'b1,32'h1,        1'b1,32'h1,        1'b1};
    vec[8]  = '{1'b1,1'b0,4'h0,4'd2,32'h0,        1'b1,1'b1,4'h0,4'd2,32'hFFFFFFFF,
                1'b1,32'h9,        1'b1,32'h9,        1'b1};
    vec[9]  = '{1'b0,1'b0,4'h0,4'd0,32'h0,        1'b1,1'b0,4'h0,4'd2,32'h0,
                1'b0,32'h9,        1'b1,32'h9,        1'b1};
    vec[10] = '{1'b0,1'b0,4'h0,4'd0,32'h0,        1'b0,1'b0,4'h0,4'd0,32'h0,
                1'b0,32'h9,        1'b0,32'h9,        1'b1};

    // Reset state
    #1 reset = 1'b1;
    #2;
    chk("rst_busy", busy, 1'b1);
    chk("rst_busy2", busy2, 1'b1);
    chk("rst_validA", validOutA, 1'b0);
    chk("rst_dataA", dataOutA, 32'h0);
    chk("rst_dataB2", dataOutB2, 32'h0);

    // Clear engine length on both sizes
    @(negedge clock) reset = 1'b0;
    n = 0; n2 = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (!busy2 && n2 == 0) n2 = k;
      if (!busy && n == 0) n = k;
      if (n != 0 && n2 != 0) break;
    end
    chk("clear_len16", n, 16);
    chk("clear_len12", n2, 12);

    // Table-driven vectors on the main instance
    for (int i = 0; i < 11; i++) begin
      set_a(vec[i].en_a, vec[i].we_a, vec[i].be_a, vec[i].ad_a, vec[i].d_a);
      set_b(vec[i].en_b, vec[i].we_b, vec[i].be_b, vec[i].ad_b, vec[i].d_b);
      tick();
      chk($sformatf("vec%0d_validA", i), validOutA, vec[i].xv_a);
      chk($sformatf("vec%0d_dataA", i), dataOutA, vec[i].xd_a);
      chk($sformatf("vec%0d_validB", i), validOutB, vec[i].xv_b);
      chk($sformatf("vec%0d_dataB", i), dataOutB, vec[i].xd_b);
`ifdef DPRAM_COLLISION_FLAG_EN
      chk($sformatf("vec%0d_col", i), collisionFlag, vec[i].xcol);
`endif
    end

`ifdef DPRAM_COLLISION_FLAG_EN
    // Clear, then clear coinciding with a new collision (set wins)
    clearCollision = 1'b1;
    tick();
    chk("col_cleared", collisionFlag, 1'b0);
    set_a(1'b1, 1'b1, 4'h1, 4'd9, 32'h0);
    set_b(1'b1, 1'b0, 4'h0, 4'd9, 32'h0);
    tick();
    chk("col_set_wins", collisionFlag, 1'b1);
    set_a(1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
    set_b(1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
    tick();
    chk("col_cleared2", collisionFlag, 1'b0);
    clearCollision = 1'b0;
`endif

    // Latency-2 back-to-back reads of 0,1,2 on u_alt
    set_a(1'b1, 1'b1, 4'hF, 4'd0, 32'h100);
    set_b(1'b1, 1'b1, 4'hF, 4'd1, 32'h101);
    tick();
    set_a(1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
    set_b(1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
    tick();
    tick();
    set_a(1'b1, 1'b0, 4'h0, 4'd0, 32'h0);
    tick();
    chk("lat_e1_main_d", dataOutA, 32'h100);
    chk("lat_e1_alt_v", validOutA2, 1'b0);
    set_a(1'b1, 1'b0, 4'h0, 4'd1, 32'h0);
    tick();
    chk("lat_e2_main_d", dataOutA, 32'h101);
    chk("lat_e2_alt_v", validOutA2, 1'b1);
    chk("lat_e2_alt_d", dataOutA2, 32'h100);
    set_a(1'b1, 1'b0, 4'h0, 4'd2, 32'h0);
    tick();
    chk("lat_e3_alt_v", validOutA2, 1'b1);
    chk("lat_e3_alt_d", dataOutA2, 32'h101);
    set_a(1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
    tick();
    chk("lat_e4_main_v", validOutA, 1'b0);
    chk("lat_e4_alt_v", validOutA2, 1'b1);
    chk("lat_e4_alt_d", dataOutA2, 32'h9);
    tick();
    chk("lat_e5_alt_v", validOutA2, 1'b0);
    chk("lat_e5_alt_hold", dataOutA2, 32'h9);

    // Read-during-write: A writes 5 to addr 2 while B reads it
    set_a(1'b1, 1'b1, 4'hF, 4'd2, 32'h5);
    set_b(1'b1, 1'b0, 4'h0, 4'd2, 32'h0);
    tick();
    chk("rdw_main_old", dataOutB, 32'h9);
    set_a(1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
    set_b(1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
    tick();
    chk("rdw_alt_new_b", dataOutB2, 32'h5);
    chk("rdw_alt_new_a", dataOutA2, 32'h5);

    // Address 13: in range on u_main, out of range on u_alt
    set_a(1'b1, 1'b1, 4'hF, 4'd13, 32'h0000DEAD);
    set_b(1'b1, 1'b0, 4'h0, 4'd13, 32'h0);
    tick();
    chk("oor_main_b", dataOutB, 32'h0);
    set_a(1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
    set_b(1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
    tick();
    chk("oor_alt_vb", validOutB2, 1'b1);
    chk("oor_alt_db", dataOutB2, 32'h0);
    chk("oor_alt_da", dataOutA2, 32'h0);
    set_a(1'b1, 1'b0, 4'h0, 4'd13, 32'h0);
    set_b(1'b1, 1'b0, 4'h0, 4'd1, 32'h0);
    tick();
    chk("oor_main_rd13", dataOutA, 32'h0000DEAD);
    chk("oor_main_rd1", dataOutB, 32'h101);
    set_a(1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
    set_b(1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
    tick();
    chk("oor_alt_rd13_v", validOutA2, 1'b1);
    chk("oor_alt_rd13", dataOutA2, 32'h0);
    chk("oor_alt_nowrap", dataOutB2, 32'h101);

    // Reset mid-clear at cycle 8, with accesses attempted throughout busy
    @(negedge clock) reset = 1'b1;
    #1;
    chk("rst2_busy", busy, 1'b1);
    chk("rst2_dataA", dataOutA, 32'h0);
    @(negedge clock) reset = 1'b0;
    repeat (8) tick();
    chk("mid_clear_busy", busy, 1'b1);
    #2 reset = 1'b1;
    set_a(1'b1, 1'b1, 4'hF, 4'd3, 32'hFFFFFFFF);
    set_b(1'b1, 1'b1, 4'hF, 4'd15, 32'hFFFFFFFF);
    @(negedge clock) reset = 1'b0;
    n = 0; n2 = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (n == 0 && (validOutA !== 1'b0 || validOutB !== 1'b0)) begin
        chk($sformatf("busy_valid_c%0d", k), {validOutA, validOutB}, 32'h0);
      end
      if (!busy2 && n2 == 0) n2 = k;
      if (!busy && n == 0) n = k;
      if (n != 0 && n2 != 0) break;
    end
    chk("reclear_len16", n, 16);
    chk("reclear_len12", n2, 12);
    set_a(1'b1, 1'b0, 4'h0, 4'd3, 32'h0);
    set_b(1'b1, 1'b0, 4'h0, 4'd15, 32'h0);
    tick();
    chk("post_clear_v", validOutA, 1'b1);
    chk("post_clear_a3", dataOutA, 32'h0);
    chk("post_clear_b15", dataOutB, 32'h0);
    set_a(1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
    set_b(1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
